// File: rtl/ipdc_host_seq.sv
// ipdc_host_seq: host-side command sequencer for the ipdc image controller.
//
// Takes one operation command at a time and issues it to ipdc once ipdc is ready.
// A load (mode 000) streams 64 pixels from a synchronous pixel memory into ipdc.
// Display modes (001-100) capture the 16 returned pixels. Completion is signalled
// with o_done once ipdc reports ready again.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   i_cmd_valid, i_cmd_mode    command request and op mode
//   o_cmd_ready                high while idle, when a command can be taken
//   o_pix_rd, o_pix_addr       pixel memory read strobe and address
//   i_pix_data                 memory data, valid the cycle after o_pix_rd
//   o_op_valid, o_op_mode      op pulse and held mode towards ipdc
//   o_in_valid, o_in_data      pixel beats towards ipdc
//   i_in_ready                 ipdc can take a new op
//   i_out_valid, i_out_data    display beats from ipdc
//   o_res_valid/_data/_idx     registered copy of accepted display beats
//   o_done                     one-cycle completion pulse
//   o_err                      sticky protocol error (unexpected display beat)
module ipdc_host_seq #(
    parameter int unsigned PixW = 24,
    parameter int unsigned NPix = 64,
    parameter int unsigned NOut = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    i_cmd_valid,
    input  logic [2:0]              i_cmd_mode,
    output logic                    o_cmd_ready,
    output logic                    o_pix_rd,
    output logic [$clog2(NPix)-1:0] o_pix_addr,
    input  logic [PixW-1:0]         i_pix_data,
    output logic                    o_op_valid,
    output logic [2:0]              o_op_mode,
    output logic                    o_in_valid,
    output logic [PixW-1:0]         o_in_data,
    input  logic                    i_in_ready,
    input  logic                    i_out_valid,
    input  logic [PixW-1:0]         i_out_data,
    output logic                    o_res_valid,
    output logic [PixW-1:0]         o_res_data,
    output logic [$clog2(NOut)-1:0] o_res_idx,
    output logic                    o_done,
    output logic                    o_err
);

    localparam int unsigned AddrW = $clog2(NPix);
    localparam int unsigned IdxW  = $clog2(NOut);
    localparam logic [AddrW-1:0] LastAddr = AddrW'(NPix - 1);
    localparam logic [IdxW-1:0]  LastBeat = IdxW'(NOut - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StLoad, StWaitDisp, StWaitRdy} state_e;

    state_e            state_q;
    logic [2:0]        mode_q;
    logic              op_valid_q;
    logic              skip_q;      // cycle right after an op pulse
    logic              pix_rd_q;
    logic [AddrW-1:0]  pix_addr_q;
    logic              dv_q;        // memory data on i_pix_data this cycle
    logic              in_valid_q;
    logic [PixW-1:0]   in_data_q;
    logic [AddrW-1:0]  in_cnt_q;
    logic              res_valid_q;
    logic [PixW-1:0]   res_data_q;
    logic [IdxW-1:0]   res_idx_q;
    logic [IdxW-1:0]   res_cnt_q;
    logic              done_q;
    logic              err_q;

    function automatic state_e op_state(input logic [2:0] mode);
        if (mode == 3'b000) begin
            return StLoad;
        end else if (mode <= 3'b100) begin
            return StWaitDisp;
        end
        return StWaitRdy;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            mode_q      <= 3'b000;
            op_valid_q  <= 1'b0;
            skip_q      <= 1'b0;
            pix_rd_q    <= 1'b0;
            pix_addr_q  <= '0;
            dv_q        <= 1'b0;
            in_valid_q  <= 1'b0;
            in_data_q   <= '0;
            in_cnt_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_cnt_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            op_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            skip_q      <= op_valid_q;
            // Memory read pipeline: strobe -> data -> registered beat.
            dv_q        <= pix_rd_q;
            in_valid_q  <= dv_q;
            if (dv_q) begin
                in_data_q <= i_pix_data;
            end
            if (i_out_valid && state_q != StWaitDisp) begin
                err_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (i_cmd_valid) begin
                        mode_q <= i_cmd_mode;
                        // Ready already high: pulse straight away, no ISSUE cycle.
                        if (i_in_ready) begin
                            op_valid_q <= 1'b1;
                            res_cnt_q  <= '0;
                            state_q    <= op_state(i_cmd_mode);
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (i_in_ready) begin
                        op_valid_q <= 1'b1;
                        res_cnt_q  <= '0;
                        state_q    <= op_state(mode_q);
                    end
                end
                StLoad: begin
                    if (op_valid_q) begin
                        pix_rd_q   <= 1'b1;
                        pix_addr_q <= '0;
                    end else if (pix_rd_q) begin
                        if (pix_addr_q == LastAddr) begin
                            pix_rd_q <= 1'b0;
                        end else begin
                            pix_addr_q <= pix_addr_q + 1'b1;
                        end
                    end
                    // Beat counter wraps back to 0 after the last pixel.
                    if (in_valid_q) begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                        if (in_cnt_q == LastAddr) begin
                            state_q <= StWaitRdy;
                        end
                    end
                end
                StWaitDisp: begin
                    if (i_out_valid) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= i_out_data;
                        res_idx_q   <= res_cnt_q;
                        res_cnt_q   <= res_cnt_q + 1'b1;
                        if (res_cnt_q == LastBeat) begin
                            state_q <= StWaitRdy;
                        end
                    end
                end
                StWaitRdy: begin
                    // ipdc still shows ready in the pulse cycle and the one after.
                    if (i_in_ready && !op_valid_q && !skip_q) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_cmd_ready = (state_q == StIdle);
    assign o_pix_rd    = pix_rd_q;
    assign o_pix_addr  = pix_addr_q;
    assign o_op_valid  = op_valid_q;
    assign o_op_mode   = mode_q;
    assign o_in_valid  = in_valid_q;
    assign o_in_data   = in_data_q;
    assign o_res_valid = res_valid_q;
    assign o_res_data  = res_data_q;
    assign o_res_idx   = res_idx_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_ipdc_host_seq.sv
// Self-checking bench for ipdc_host_seq. The bench plays pixel memory and ipdc;
// expected values come from the documented cycle timing and the stored pixels.
module tb_ipdc_host_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic [2:0]  i_cmd_mode = 3'b000;
    logic        o_cmd_ready;
    logic        o_pix_rd;
    logic [5:0]  o_pix_addr;
    logic [23:0] i_pix_data = '0;
    logic        o_op_valid;
    logic [2:0]  o_op_mode;
    logic        o_in_valid;
    logic [23:0] o_in_data;
    logic        i_in_ready = 1'b0;
    logic        i_out_valid = 1'b0;
    logic [23:0] i_out_data = '0;
    logic        o_res_valid;
    logic [23:0] o_res_data;
    logic [3:0]  o_res_idx;
    logic        o_done;
    logic        o_err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic        exp_err = 1'b0;
    logic [23:0] mem [64];

    ipdc_host_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_mode  (i_cmd_mode),
        .o_cmd_ready (o_cmd_ready),
        .o_pix_rd    (o_pix_rd),
        .o_pix_addr  (o_pix_addr),
        .i_pix_data  (i_pix_data),
        .o_op_valid  (o_op_valid),
        .o_op_mode   (o_op_mode),
        .o_in_valid  (o_in_valid),
        .o_in_data   (o_in_data),
        .i_in_ready  (i_in_ready),
        .i_out_valid (i_out_valid),
        .i_out_data  (i_out_data),
        .o_res_valid (o_res_valid),
        .o_res_data  (o_res_data),
        .o_res_idx   (o_res_idx),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous pixel memory: data one cycle after the read strobe.
    always @(posedge clk_i) begin
        if (o_pix_rd) i_pix_data <= mem[o_pix_addr];
    end

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic send_cmd(input logic [2:0] m);
        i_cmd_valid = 1'b1;
        i_cmd_mode  = m;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd_mode  = 3'($urandom);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        i_cmd_valid = 1'b0;
        i_in_ready = 1'b0;
        i_out_valid = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        exp_err = 1'b0;
        tick();
        n_checks++;
        if (o_cmd_ready !== 1'b1) begin
            $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready);
            n_fail++;
        end
        n_checks++;
        if ({o_pix_rd, o_pix_addr, o_op_valid, o_op_mode, o_in_valid, o_in_data, o_res_valid,
             o_res_data, o_res_idx, o_done, o_err} !== '0) begin
            $display("FAIL reset_outputs: got rd=%b addr=%0d op=%b mode=%0d iv=%b id=%h rv=%b rd=%h ri=%0d done=%b err=%b want all 0",
                     o_pix_rd, o_pix_addr, o_op_valid, o_op_mode, o_in_valid, o_in_data,
                     o_res_valid, o_res_data, o_res_idx, o_done, o_err);
            n_fail++;
        end
    endtask

    // Load; abort_at > 0 asserts reset in cycle T+abort_at.
    task automatic test_load(input bit rnd, input int abort_at);
        int dly;
        for (int k = 0; k < 64; k++) mem[k] = rnd ? 24'($urandom) : 24'(k * 24'h010101);
        i_in_ready = 1'b1;
        send_cmd(3'b000);
        n_checks++;
        if (o_op_valid !== 1'b1 || o_op_mode !== 3'b000 || o_cmd_ready !== 1'b0) begin
            $display("FAIL load_issue: got op=%b mode=%0d rdy=%b want 1 0 0",
                     o_op_valid, o_op_mode, o_cmd_ready);
            n_fail++;
        end
        i_in_ready = 1'b0;
        for (int t = 1; t <= 66; t++) begin
            tick();
            n_checks++;
            if (o_pix_rd !== (t <= 64) || (t <= 64 && o_pix_addr !== 6'(t - 1))) begin
                $display("FAIL load_rd t=%0d: got rd=%b addr=%0d want rd=%b addr=%0d",
                         t, o_pix_rd, o_pix_addr, (t <= 64), t - 1);
                n_fail++;
            end
            n_checks++;
            if (o_in_valid !== (t >= 3) || (t >= 3 && o_in_data !== mem[t - 3])) begin
                $display("FAIL load_beat t=%0d: got v=%b d=%h want v=%b d=%h",
                         t, o_in_valid, o_in_data, (t >= 3), (t >= 3) ? mem[t - 3] : 24'h0);
                n_fail++;
            end
            if (t == abort_at) begin
                rst_ni = 1'b0;
                tick();
                rst_ni = 1'b1;
                exp_err = 1'b0;
                n_checks++;
                if (o_cmd_ready !== 1'b1 || {o_pix_rd, o_pix_addr, o_op_valid, o_op_mode,
                    o_in_valid, o_in_data, o_res_valid, o_res_data, o_res_idx, o_done,
                    o_err} !== '0) begin
                    $display("FAIL abort_reset: got rdy=%b rd=%b addr=%0d iv=%b id=%h done=%b want 1 and zeros",
                             o_cmd_ready, o_pix_rd, o_pix_addr, o_in_valid, o_in_data, o_done);
                    n_fail++;
                end
                return;
            end
        end
        dly = $urandom_range(0, 4);
        for (int c = 0; c <= dly; c++) begin
            tick();
            n_checks++;
            if (o_in_valid !== 1'b0 || o_done !== 1'b0 || o_pix_rd !== 1'b0) begin
                $display("FAIL load_tail: got iv=%b done=%b rd=%b want 0 0 0",
                         o_in_valid, o_done, o_pix_rd);
                n_fail++;
            end
        end
        i_in_ready = 1'b1;
        tick();
        n_checks++;
        if (o_done !== 1'b1 || o_cmd_ready !== 1'b1 || o_err !== exp_err) begin
            $display("FAIL load_done: got done=%b rdy=%b err=%b want 1 1 %b",
                     o_done, o_cmd_ready, o_err, exp_err);
            n_fail++;
        end
        tick();
        n_checks++;
        if (o_done !== 1'b0) begin
            $display("FAIL load_done_pulse: got done=%b want 0", o_done);
            n_fail++;
        end
    endtask

    task automatic test_display(input logic [2:0] m, input bit fixed, input bit extra);
        logic [23:0] d;
        int gap;
        int dly;
        i_in_ready = 1'b1;
        send_cmd(m);
        n_checks++;
        if (o_op_valid !== 1'b1 || o_op_mode !== m) begin
            $display("FAIL disp_issue: got op=%b mode=%0d want 1 %0d", o_op_valid, o_op_mode, m);
            n_fail++;
        end
        i_in_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                n_checks++;
                if (o_res_valid !== 1'b0) begin
                    $display("FAIL disp_gap: got rv=%b want 0", o_res_valid);
                    n_fail++;
                end
            end
            d = fixed ? 24'hA00000 + 24'(i) : 24'($urandom);
            i_out_valid = 1'b1;
            i_out_data  = d;
            tick();
            i_out_valid = 1'b0;
            n_checks++;
            if (o_res_valid !== 1'b1 || o_res_idx !== 4'(i) || o_res_data !== d) begin
                $display("FAIL disp_beat %0d: got v=%b idx=%0d d=%h want 1 %0d %h",
                         i, o_res_valid, o_res_idx, o_res_data, i, d);
                n_fail++;
            end
        end
        if (extra) begin
            i_out_valid = 1'b1;
            i_out_data  = 24'($urandom);
            tick();
            i_out_valid = 1'b0;
            exp_err = 1'b1;
            n_checks++;
            if (o_res_valid !== 1'b0 || o_err !== 1'b1) begin
                $display("FAIL disp_beat17: got rv=%b err=%b want 0 1", o_res_valid, o_err);
                n_fail++;
            end
        end
        dly = $urandom_range(0, 3);
        for (int c = 0; c < dly; c++) begin
            tick();
            n_checks++;
            if (o_done !== 1'b0) begin
                $display("FAIL disp_wait: got done=%b want 0", o_done);
                n_fail++;
            end
        end
        i_in_ready = 1'b1;
        tick();
        n_checks++;
        if (o_done !== 1'b1 || o_err !== exp_err || o_cmd_ready !== 1'b1) begin
            $display("FAIL disp_done: got done=%b err=%b rdy=%b want 1 %b 1",
                     o_done, o_err, o_cmd_ready, exp_err);
            n_fail++;
        end
        tick();
        n_checks++;
        if (o_done !== 1'b0) begin
            $display("FAIL disp_done_pulse: got done=%b want 0", o_done);
            n_fail++;
        end
    endtask

    task automatic test_wait_rdy(input logic [2:0] m, input int low);
        i_in_ready = 1'b1;
        send_cmd(m);
        n_checks++;
        if (o_op_valid !== 1'b1 || o_op_mode !== m) begin
            $display("FAIL rdy_issue: got op=%b mode=%0d want 1 %0d", o_op_valid, o_op_mode, m);
            n_fail++;
        end
        // Ready stays high through the pulse cycle and the skip cycle.
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (o_done !== 1'b0) begin
                $display("FAIL rdy_skip %0d: got done=%b want 0", c, o_done);
                n_fail++;
            end
        end
        i_in_ready = 1'b0;
        for (int c = 0; c < low; c++) begin
            tick();
            n_checks++;
            if (o_done !== 1'b0 || o_op_mode !== m) begin
                $display("FAIL rdy_low: got done=%b mode=%0d want 0 %0d", o_done, o_op_mode, m);
                n_fail++;
            end
        end
        i_in_ready = 1'b1;
        tick();
        n_checks++;
        if (o_done !== 1'b1 || o_cmd_ready !== 1'b1) begin
            $display("FAIL rdy_done: got done=%b rdy=%b want 1 1", o_done, o_cmd_ready);
            n_fail++;
        end
    endtask

    task automatic test_issue_stall();
        i_in_ready = 1'b0;
        send_cmd(3'b110);
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (o_op_valid !== 1'b0 || o_cmd_ready !== 1'b0) begin
                $display("FAIL stall_%0d: got op=%b rdy=%b want 0 0", c, o_op_valid, o_cmd_ready);
                n_fail++;
            end
            i_cmd_valid = 1'b1;
            i_cmd_mode  = 3'b001;
            tick();
        end
        i_cmd_valid = 1'b0;
        i_in_ready = 1'b1;
        tick();
        n_checks++;
        if (o_op_valid !== 1'b1 || o_op_mode !== 3'b110) begin
            $display("FAIL stall_issue: got op=%b mode=%0d want 1 6", o_op_valid, o_op_mode);
            n_fail++;
        end
        tick();
        tick();
        n_checks++;
        if (o_done !== 1'b0) begin
            $display("FAIL stall_early_done: got done=%b want 0", o_done);
            n_fail++;
        end
        tick();
        n_checks++;
        if (o_done !== 1'b1) begin
            $display("FAIL stall_done: got done=%b want 1", o_done);
            n_fail++;
        end
    endtask

    task automatic test_stray_err();
        i_out_valid = 1'b1;
        i_out_data  = 24'($urandom);
        tick();
        i_out_valid = 1'b0;
        exp_err = 1'b1;
        n_checks++;
        if (o_res_valid !== 1'b0 || o_err !== 1'b1) begin
            $display("FAIL stray_err: got rv=%b err=%b want 0 1", o_res_valid, o_err);
            n_fail++;
        end
        repeat (3) tick();
        n_checks++;
        if (o_err !== 1'b1) begin
            $display("FAIL stray_sticky: got err=%b want 1", o_err);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        i_in_ready = 1'b1;
        send_cmd(3'b111);
        tick();
        tick();
        tick();
        n_checks++;
        if (o_done !== 1'b1 || o_cmd_ready !== 1'b1) begin
            $display("FAIL b2b_done1: got done=%b rdy=%b want 1 1", o_done, o_cmd_ready);
            n_fail++;
        end
        send_cmd(3'b101);
        n_checks++;
        if (o_op_valid !== 1'b1 || o_op_mode !== 3'b101 || o_done !== 1'b0) begin
            $display("FAIL b2b_issue: got op=%b mode=%0d done=%b want 1 5 0",
                     o_op_valid, o_op_mode, o_done);
            n_fail++;
        end
        tick();
        tick();
        n_checks++;
        if (o_done !== 1'b0) begin
            $display("FAIL b2b_early: got done=%b want 0", o_done);
            n_fail++;
        end
        tick();
        n_checks++;
        if (o_done !== 1'b1) begin
            $display("FAIL b2b_done2: got done=%b want 1", o_done);
            n_fail++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk_i);
        test_reset();
        test_load(1'b0, 0);
        test_display(3'b011, 1'b1, 1'b0);
        test_display(3'($urandom_range(1, 4)), 1'b0, 1'b0);
        test_wait_rdy(3'b101, 5);
        test_wait_rdy(3'($urandom_range(5, 7)), $urandom_range(1, 6));
        test_issue_stall();
        test_stray_err();
        test_reset();
        test_display(3'b010, 1'b0, 1'b1);
        test_load(1'b1, 33);
        test_load(1'b1, 0);
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
